// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, datapath widths and the operand bundle
// carried from a requester to the ALU ports.
package alu_pkg;

    localparam int XLEN      = 32;
    localparam int ALUCTRL_W = 4;

    typedef enum logic [ALUCTRL_W-1:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_XOR   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_AND   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_LUI   = 4'd10,
        ALU_AUIPC = 4'd11
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0]      src_a;
        logic [XLEN-1:0]      src_b;
        logic [XLEN-1:0]      pc;
        logic [ALUCTRL_W-1:0] ctrl;
        logic                 imm;
        logic                 srca_sel;
    } alu_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or above rr_ptr wins,
// wrapping to index 0. The pointer register itself lives in the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id
);

    logic found;

    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        // Upper segment [rr_ptr, NUM_REQ) first, then the wrapped segment.
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j] && (j >= int'(rr_ptr))) begin
                found  = 1'b1;
                gnt_id = ID_W'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt_id = ID_W'(j);
            end
        end
        gnt = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            gnt[j] = found && (gnt_id == ID_W'(j));
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters: round-robin grant,
// operand register (S1) on the ALU ports, tagged result register (S2) out.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                   CLK,
    input  logic                   RESETn,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*32-1:0]  req_src_a,
    input  logic [NUM_REQ*32-1:0]  req_src_b,
    input  logic [NUM_REQ*4-1:0]   req_ctrl,
    input  logic [NUM_REQ*32-1:0]  req_pc,
    input  logic [NUM_REQ-1:0]     req_imm,
    input  logic [NUM_REQ-1:0]     req_srca_sel,
    input  logic                   flush,
    output logic [31:0]            alu_src_a,
    output logic [31:0]            alu_src_b,
    output logic [31:0]            alu_pc,
    output logic [3:0]             alu_control,
    output logic                   alu_imm,
    output logic                   alu_srca_sel,
    input  logic [31:0]            alu_result,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [31:0]            resp_result,
    output logic                   busy
);

    // Handshake: a request transfers on an edge where req_valid[i] && req_ready[i];
    // a response transfers where resp_valid && resp_ready. Neither ready depends
    // on the same-side valid of the other channel, only on pipeline occupancy.

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    win_id;
    logic [NUM_REQ-1:0] gnt;
    alu_req_t           win_op;
    alu_req_t           s1_op;
    logic               s1_valid;
    logic [ID_W-1:0]    s1_id;
    logic               s2_valid;
    logic [ID_W-1:0]    s2_id;
    logic [31:0]        s2_result;
    logic               s2_adv;
    logic               s1_free;
    logic               grant_en;
    logic               grant_fire;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr_arbiter (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .gnt    (gnt),
        .gnt_id (win_id)
    );

    assign s2_adv     = s1_valid && (!s2_valid || resp_ready);
    assign s1_free    = !s1_valid || s2_adv;
    assign grant_en   = s1_free && !flush && RESETn;
    assign req_ready  = grant_en ? gnt : '0;
    assign grant_fire = grant_en && (|req_valid);

    always_comb begin
        win_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_op.src_a    = req_src_a[32*i +: 32];
                win_op.src_b    = req_src_b[32*i +: 32];
                win_op.pc       = req_pc[32*i +: 32];
                win_op.ctrl     = req_ctrl[4*i +: 4];
                win_op.imm      = req_imm[i];
                win_op.srca_sel = req_srca_sel[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            rr_ptr    <= '0;
            s1_valid  <= 1'b0;
            s1_op     <= '0;
            s1_id     <= '0;
            s2_valid  <= 1'b0;
            s2_id     <= '0;
            s2_result <= '0;
        end else begin
            if (grant_fire) begin
                rr_ptr <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
            end

            if (flush) begin
                s1_valid <= 1'b0;
            end else if (grant_fire) begin
                s1_valid <= 1'b1;
                s1_op    <= win_op;
                s1_id    <= win_id;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end

            // A result sitting in S2 during flush is dropped, even if resp_ready.
            if (flush) begin
                s2_valid <= 1'b0;
            end else if (s2_adv) begin
                s2_valid  <= 1'b1;
                s2_result <= alu_result;
                s2_id     <= s1_id;
            end else if (resp_ready && s2_valid && !s1_valid) begin
                s2_valid <= 1'b0;
            end
        end
    end

    assign alu_src_a    = s1_op.src_a;
    assign alu_src_b    = s1_op.src_b;
    assign alu_pc       = s1_op.pc;
    assign alu_control  = s1_op.ctrl;
    assign alu_imm      = s1_op.imm;
    assign alu_srca_sel = s1_op.srca_sel;

    assign resp_valid  = s2_valid;
    assign resp_id     = s2_id;
    assign resp_result = s2_result;
    assign busy        = s1_valid || s2_valid;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed + random bench for alu_share_arbiter with a stub ALU and a
// transaction-level model of grant order, occupancy and returned results.
`timescale 1ns/1ps
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int N  = 2;
    localparam int IW = 1;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RESETn;
    always #5 CLK = ~CLK;

    logic [N-1:0]    req_valid, req_ready, req_imm, req_srca_sel;
    logic [N*32-1:0] req_src_a, req_src_b, req_pc;
    logic [N*4-1:0]  req_ctrl;
    logic            flush, resp_valid, resp_ready, busy;
    logic [31:0]     alu_src_a, alu_src_b, alu_pc, alu_result, resp_result;
    logic [3:0]      alu_control;
    logic            alu_imm, alu_srca_sel;
    logic [IW-1:0]   resp_id;

    alu_share_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src_a(req_src_a), .req_src_b(req_src_b), .req_ctrl(req_ctrl),
        .req_pc(req_pc), .req_imm(req_imm), .req_srca_sel(req_srca_sel),
        .flush(flush),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_pc(alu_pc),
        .alu_control(alu_control), .alu_imm(alu_imm), .alu_srca_sel(alu_srca_sel),
        .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_result(resp_result), .busy(busy)
    );

    // Stub RV32I ALU, also used to compute expected results from requester fields.
    function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] pc,
                                           input logic sel);
        logic [31:0] x;
        x = sel ? pc : a;
        case (c)
            ALU_ADD:   return x + b;
            ALU_SUB:   return x - b;
            ALU_XOR:   return x ^ b;
            ALU_OR:    return x | b;
            ALU_AND:   return x & b;
            ALU_SLL:   return x << b[4:0];
            ALU_SRL:   return x >> b[4:0];
            ALU_SRA:   return $signed(x) >>> b[4:0];
            ALU_SLT:   return {31'b0, $signed(x) < $signed(b)};
            ALU_SLTU:  return {31'b0, x < b};
            ALU_LUI:   return b;
            ALU_AUIPC: return pc + b;
            default:   return 32'h0;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_control, alu_src_a, alu_src_b, alu_pc, alu_srca_sel);

    // ---------------- scoreboard / model state ----------------
    int total = 0;
    int bad   = 0;
    logic [IW+31:0] exp_q[$];
    int   rr_m;
    bit   fresh;
    logic [31:0] last_a, last_b, last_pc;
    logic [3:0]  last_c;
    logic        last_imm, last_sel;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        rr_m = 0; fresh = 0;
        last_a = '0; last_b = '0; last_pc = '0; last_c = '0; last_imm = 0; last_sel = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_op(input int i, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] pc,
                          input logic imm, input logic sel);
        req_ctrl[4*i +: 4]   = c;
        req_src_a[32*i +: 32] = a;
        req_src_b[32*i +: 32] = b;
        req_pc[32*i +: 32]   = pc;
        req_imm[i]           = imm;
        req_srca_sel[i]      = sel;
    endtask

    task automatic rand_op(input int i);
        set_op(i, 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    // One clock: check outputs at the falling edge against the model, then
    // advance the model across the rising edge. gidx = granted requester or -1.
    task automatic step(output int gidx);
        int n, w;
        bit can, rv_exp;
        logic [N-1:0] exp_rdy;
        logic [31:0] res;
        @(negedge CLK);
        n   = exp_q.size();
        can = (n < 2 || resp_ready) && !flush;
        w   = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (rr_m + k) % N;
            if (w < 0 && req_valid[j]) w = j;
        end
        exp_rdy = '0;
        if (can && w >= 0) exp_rdy[w] = 1'b1;
        rv_exp = (n == 2) || (n == 1 && !fresh);
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("resp_valid", 32'(resp_valid), 32'(rv_exp));
        check("busy", 32'(busy), 32'(n > 0));
        if (rv_exp) begin
            check("resp_id", 32'(resp_id), 32'(exp_q[0][IW+31:32]));
            check("resp_result", resp_result, exp_q[0][31:0]);
        end
        check("alu_src_a", alu_src_a, last_a);
        check("alu_src_b", alu_src_b, last_b);
        check("alu_pc", alu_pc, last_pc);
        check("alu_ctrl", 32'(alu_control), 32'(last_c));
        check("alu_flags", 32'({alu_imm, alu_srca_sel}), 32'({last_imm, last_sel}));
        gidx = -1;
        if (flush) begin
            exp_q.delete();
            fresh = 0;
        end else begin
            if (rv_exp && resp_ready) void'(exp_q.pop_front());
            if (can && w >= 0) begin
                last_a   = req_src_a[32*w +: 32];
                last_b   = req_src_b[32*w +: 32];
                last_pc  = req_pc[32*w +: 32];
                last_c   = req_ctrl[4*w +: 4];
                last_imm = req_imm[w];
                last_sel = req_srca_sel[w];
                res = alu_fn(last_c, last_a, last_b, last_pc, last_sel);
                exp_q.push_back({IW'(w), res});
                rr_m  = (w + 1) % N;
                fresh = 1;
                gidx  = w;
            end else begin
                fresh = 0;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int g, k;
        logic [3:0]  bp_c[3];
        logic [31:0] bp_a[3], bp_b[3];

        RESETn = 0; flush = 0; resp_ready = 1;
        req_valid = '1; req_ctrl = '0; req_src_a = '0; req_src_b = '0;
        req_pc = '0; req_imm = '0; req_srca_sel = '0;
        model_reset();
        #3;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_alu_a", alu_src_a, 32'h0);
        check("rst_resp_result", resp_result, 32'h0);
        req_valid = '0;
        @(posedge CLK); #1;
        RESETn = 1;

        // Single op: req0 ADD 5+7.
        set_op(0, ALU_ADD, 32'd5, 32'd7, 32'h0, 0, 0);
        req_valid = 2'b01;
        step(g);
        req_valid = '0;
        check("single_alu_a", alu_src_a, 32'd5);
        check("single_alu_b", alu_src_b, 32'd7);
        step(g);
        check("single_resp_valid", 32'(resp_valid), 32'h1);
        check("single_result", resp_result, 32'd12);
        check("single_id", 32'(resp_id), 32'h0);
        step(g);

        // Fairness: both requesters held valid, random ops.
        for (int i = 0; i < 8; i++) begin
            rand_op(0); rand_op(1);
            req_valid = 2'b11;
            step(g);
        end
        req_valid = '0;
        step(g); step(g);

        // Backpressure: three ops from req1 while the consumer stalls.
        bp_c[0] = ALU_SUB; bp_a[0] = 32'd10;   bp_b[0] = 32'd3;
        bp_c[1] = ALU_XOR; bp_a[1] = 32'hF0;   bp_b[1] = 32'h0F;
        bp_c[2] = ALU_OR;  bp_a[2] = 32'd1;    bp_b[2] = 32'd2;
        resp_ready = 0;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            req_valid = (k < 3) ? 2'b10 : 2'b00;
            if (k < 3) set_op(1, bp_c[k], bp_a[k], bp_b[k], 32'h0, 0, 0);
            step(g);
            if (g == 1) k++;
        end
        check("bp_hold_result", resp_result, 32'd7);
        check("bp_hold_id", 32'(resp_id), 32'h1);
        check("bp_blocked", 32'(req_ready), 32'h0);
        resp_ready = 1;
        for (int i = 0; i < 6; i++) begin
            req_valid = (k < 3) ? 2'b10 : 2'b00;
            if (k < 3) set_op(1, bp_c[k], bp_a[k], bp_b[k], 32'h0, 0, 0);
            step(g);
            if (g == 1) k++;
        end
        check("bp_drained", 32'(busy), 32'h0);

        // Flush with S1 and S2 full and req0 pending.
        resp_ready = 0;
        rand_op(0); req_valid = 2'b01; step(g);
        rand_op(1); req_valid = 2'b10; step(g);
        rand_op(0); req_valid = 2'b01; flush = 1;
        step(g);
        flush = 0;
        check("flush_resp_valid", 32'(resp_valid), 32'h0);
        check("flush_busy", 32'(busy), 32'h0);
        req_valid = 2'b11; rand_op(1); resp_ready = 1;
        step(g);
        req_valid = '0;
        step(g); step(g);

        // Asynchronous reset between edges with S2 full.
        resp_ready = 0;
        rand_op(1); req_valid = 2'b10; step(g);
        req_valid = '0; step(g);
        #1 RESETn = 0;
        #1;
        check("arst_resp_valid", 32'(resp_valid), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_alu_a", alu_src_a, 32'h0);
        check("arst_alu_ctrl", 32'(alu_control), 32'h0);
        check("arst_req_ready", 32'(req_ready), 32'h0);
        model_reset();
        #1 RESETn = 1;
        resp_ready = 1;
        rand_op(0); req_valid = 2'b01; step(g);
        req_valid = '0; step(g); step(g);

        // Pass-through: req1 AUIPC with PC as operand A.
        set_op(1, ALU_AUIPC, 32'h0, 32'h2, 32'h1000, 0, 1);
        req_valid = 2'b10;
        step(g);
        req_valid = '0;
        check("pt_alu_pc", alu_pc, 32'h1000);
        check("pt_srca_sel", 32'(alu_srca_sel), 32'h1);
        check("pt_ctrl", 32'(alu_control), 32'd11);
        step(g);
        check("pt_result", resp_result, 32'h1002);
        step(g);

        // Random traffic with backpressure and occasional flush.
        for (int i = 0; i < 300; i++) begin
            rand_op(0); rand_op(1);
            req_valid  = N'($urandom_range(0, 3));
            resp_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 24) == 0);
            step(g);
        end
        flush = 0; req_valid = '0; resp_ready = 1;
        step(g); step(g); step(g);
        check("final_idle", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
